// File: rtl/mmss_timer.sv
// mmss_timer -- prescaled minutes:seconds up/down timer.
//
// A PRE_W-bit prescaler divides mclk down to a once-per-second tick. Each tick
// moves the MM:SS time register up or down. Counting up wraps from
// MIN_MAX:59 to 00:00. Counting down stops at 00:00, raises a done strobe, and
// then freezes until a nonzero load arrives or mode returns to up.
//
// Ports:
//   mclk      in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   enable    in   count gate; the prescaler advances only while high
//   mode      in   0 = count up, 1 = count down
//   clear     in   synchronous zero of time and prescaler
//   load      in   synchronous saturating load of load_min/load_sec
//   load_min  in   [6:0] minutes value for load
//   load_sec  in   [5:0] seconds value for load
//   sec       out  one-cycle strobe per elapsed second
//   done      out  one-cycle strobe when a down-count reaches 00:00
//   expired   out  level: mode==1 and time==00:00
//   r_min     out  [6:0] current minutes
//   r_sec     out  [5:0] current seconds
module mmss_timer #(
  parameter int unsigned CLK_HZ  = 32000000,
  parameter int unsigned PRE_W   = 25,
  parameter int unsigned MIN_MAX = 99
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       enable,
  input  logic       mode,
  input  logic       clear,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  output logic       sec,
  output logic       done,
  output logic       expired,
  output logic [6:0] r_min,
  output logic [5:0] r_sec
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [6:0]       MIN_LAST = 7'(MIN_MAX);
  localparam logic [5:0]       SEC_LAST = 6'd59;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [6:0]       min_q, min_d;
  logic [5:0]       tsec_q, tsec_d;
  logic             sec_q, sec_d;
  logic             done_q, done_d;
  logic             expired_s;
  logic             advance_s;
  logic             tick_s;

  // Expiry is a level on the registered time, so it follows mode directly
  // (including while rst is held).
  assign expired_s = mode & (min_q == 7'd0) & (tsec_q == 6'd0);
  assign advance_s = enable & ~expired_s;
  assign tick_s    = advance_s & (pre_q == PRE_LAST);

  // Next-state logic: clear beats load beats tick; strobes default low so a
  // tick coinciding with clear or load is discarded.
  always_comb begin
    pre_d  = pre_q;
    min_d  = min_q;
    tsec_d = tsec_q;
    sec_d  = 1'b0;
    done_d = 1'b0;
    if (clear) begin
      pre_d  = PRE_ZERO;
      min_d  = 7'd0;
      tsec_d = 6'd0;
    end else if (load) begin
      pre_d  = PRE_ZERO;
      min_d  = (load_min > MIN_LAST) ? MIN_LAST : load_min;
      tsec_d = (load_sec > SEC_LAST) ? SEC_LAST : load_sec;
    end else if (tick_s) begin
      pre_d = PRE_ZERO;
      sec_d = 1'b1;
      if (mode) begin
        // Ticks never happen at 00:00 in down mode, so the borrow from
        // minutes is always safe.
        if (tsec_q == 6'd0) begin
          tsec_d = SEC_LAST;
          min_d  = min_q - 7'd1;
        end else begin
          tsec_d = tsec_q - 6'd1;
        end
        done_d = (min_q == 7'd0) && (tsec_q == 6'd1);
      end else begin
        if (tsec_q >= SEC_LAST) begin
          tsec_d = 6'd0;
          if (min_q >= MIN_LAST) begin
            min_d = 7'd0;
          end else begin
            min_d = min_q + 7'd1;
          end
        end else begin
          tsec_d = tsec_q + 6'd1;
        end
      end
    end else if (advance_s) begin
      pre_d = pre_q + PRE_ONE;
    end else begin
      pre_d = pre_q;
    end
  end

  // State and strobe registers.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      pre_q  <= PRE_ZERO;
      min_q  <= 7'd0;
      tsec_q <= 6'd0;
      sec_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      min_q  <= min_d;
      tsec_q <= tsec_d;
      sec_q  <= sec_d;
      done_q <= done_d;
    end
  end

  assign sec     = sec_q;
  assign done    = done_q;
  assign expired = expired_s;
  assign r_min   = min_q;
  assign r_sec   = tsec_q;

endmodule

// File: tb/tb_mmss_timer.sv
// Scoreboard bench for mmss_timer (CLK_HZ=10, MIN_MAX=3).
// The reference model keeps the time as a single count of seconds plus a
// count of enabled cycles into the current second.
module tb_mmss_timer;

  localparam int CLK_HZ  = 10;
  localparam int MIN_MAX = 3;
  localparam int TOTAL   = (MIN_MAX + 1) * 60;

  logic       mclk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [6:0] load_min = 7'd0;
  logic [5:0] load_sec = 6'd0;
  logic       sec, done, expired;
  logic [6:0] r_min;
  logic [5:0] r_sec;

  mmss_timer #(.CLK_HZ(CLK_HZ), .PRE_W(8), .MIN_MAX(MIN_MAX)) dut (
    .mclk(mclk), .rst(rst), .enable(enable), .mode(mode), .clear(clear),
    .load(load), .load_min(load_min), .load_sec(load_sec), .sec(sec),
    .done(done), .expired(expired), .r_min(r_min), .r_sec(r_sec)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic       s;
    logic       d;
    logic       e;
    logic [6:0] m;
    logic [5:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state.
  int m_t  = 0;  // total seconds
  int m_ph = 0;  // enabled cycles into current second
  bit m_sp = 0;
  bit m_dp = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Advances the model by one mclk edge using the current bench inputs and
  // returns the outputs expected just after that edge.
  function automatic exp_t model_edge();
    exp_t e;
    bit   was_exp;
    if (rst) begin
      m_t = 0; m_ph = 0; m_sp = 0; m_dp = 0;
    end else if (clear) begin
      m_t = 0; m_ph = 0; m_sp = 0; m_dp = 0;
    end else if (load) begin
      m_t  = imin(int'(load_min), MIN_MAX) * 60 + imin(int'(load_sec), 59);
      m_ph = 0; m_sp = 0; m_dp = 0;
    end else begin
      m_sp = 0; m_dp = 0;
      was_exp = mode && (m_t == 0);
      if (enable && !was_exp) begin
        m_ph++;
        if (m_ph == CLK_HZ) begin
          m_ph = 0;
          m_sp = 1;
          if (mode) begin
            m_t--;
            m_dp = (m_t == 0);
          end else begin
            m_t = (m_t + 1) % TOTAL;
          end
        end
      end
    end
    e.s  = m_sp;
    e.d  = m_dp;
    e.e  = mode && (m_t == 0);
    e.m  = 7'(m_t / 60);
    e.sc = 6'(m_t % 60);
    return e;
  endfunction

  // One clock cycle of stimulus; the expected response goes to the scoreboard.
  task automatic step(input bit rst_i, input bit en_i, input bit md_i,
                      input bit clr_i, input bit ld_i,
                      input logic [6:0] lm_i, input logic [5:0] ls_i);
    @(negedge mclk);
    rst = rst_i; enable = en_i; mode = md_i; clear = clr_i; load = ld_i;
    load_min = lm_i; load_sec = ls_i;
    exp_q.push_back(model_edge());
  endtask

  task automatic run(input int n, input bit en_i, input bit md_i);
    for (int i = 0; i < n; i++) step(1'b0, en_i, md_i, 1'b0, 1'b0, 7'd0, 6'd0);
  endtask

  task automatic do_load(input bit md_i, input logic [6:0] lm_i, input logic [5:0] ls_i);
    step(1'b0, 1'b1, md_i, 1'b0, 1'b1, lm_i, ls_i);
  endtask

  // Immediate check used for the asynchronous-reset case.
  task automatic check_now(input string name, input exp_t want);
    exp_t got;
    got = {sec, done, expired, r_min, r_sec};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got sec=%0b done=%0b exp=%0b %0d:%0d, want sec=%0b done=%0b exp=%0b %0d:%0d",
               name, got.s, got.d, got.e, got.m, got.sc, want.s, want.d, want.e, want.m, want.sc);
    end
  endtask

  // Monitor: pops one expectation per edge and compares the DUT outputs.
  initial begin
    exp_t want;
    forever begin
      @(posedge mclk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check_now("scoreboard", want);
      end
    end
  end

  initial begin
    exp_t z;
    bit   md;
    // Reset state, held for a few edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);

    // Up count through a full wrap: 240 ticks plus a margin.
    run(40 * 10 * 6 + 20, 1'b1, 1'b0);

    // Down count 00:02 to expiry, then stay frozen.
    do_load(1'b1, 7'd0, 6'd2);
    run(20 + 50, 1'b1, 1'b1);

    // Saturating load, then one tick wraps to 00:00.
    do_load(1'b0, 7'd7, 6'd75);
    run(12, 1'b1, 1'b0);

    // Load and clear together on the would-be tick edge.
    do_load(1'b0, 7'd1, 6'd10);
    run(9, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'd2, 6'd5);
    run(12, 1'b1, 1'b0);

    // Enable gap mid-second.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 6'd0);
    run(6, 1'b1, 1'b0);
    run(20, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    run(6, 1'b1, 1'b0);

    // Mode change mid-second and expiry exit by mode->0.
    do_load(1'b1, 7'd0, 6'd1);
    run(5, 1'b1, 1'b0);
    run(10, 1'b1, 1'b1);
    run(15, 1'b1, 1'b0);

    // Randomised traffic.
    md = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) md = ~md;
      step(1'b0, ($urandom_range(99) < 85), md,
           ($urandom_range(63) == 0), ($urandom_range(31) == 0),
           7'($urandom_range(127)), 6'($urandom_range(63)));
    end

    // Asynchronous reset mid-second during a down count at 01:30.
    do_load(1'b1, 7'd1, 6'd30);
    run(15, 1'b1, 1'b1);
    @(posedge mclk);
    #3;
    rst = 1'b1;
    #1;
    z = '0;
    z.e = 1'b1;
    check_now("async_rst", z);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    run(30, 1'b1, 1'b1);

    // Let the last expectations drain.
    repeat (3) @(posedge mclk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
